// File: rtl/serial_frame_arbiter.sv
// Round-robin arbiter that lends one serial "11"-pair detector to N_REQ requesters,
// one fixed-length frame at a time, and reports a one-cycle result per frame.
//
// state  | meaning
// IDLE   | no owner; round-robin search from last_owner+1
// STREAM | owner granted; one bit sampled per cycle into the pair detector
// REPORT | one-cycle result pulse; owner becomes last_owner
module serial_frame_arbiter #(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 8,
  localparam int ID_W     = $clog2(N_REQ),
  localparam int CNT_W    = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  x_in,
  output logic [N_REQ-1:0]  gnt,
  output logic              busy,
  output logic              done,
  output logic [ID_W-1:0]   done_id,
  output logic              done_hit,
  output logic              done_abort
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  last_owner_q, last_owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q, prev_d;
  logic             hit_q, hit_d;
  logic [ID_W-1:0]  done_id_q, done_id_d;
  logic             done_hit_q, done_hit_d;
  logic             done_abort_q, done_abort_d;

  logic             pick_valid;
  logic [ID_W-1:0]  pick_id;
  logic [ID_W-1:0]  cand;
  int               sum;
  logic             bit_s;
  logic             hit_next;

  // Scan from farthest to nearest so the requester closest after last_owner wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    sum        = 0;
    cand       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      sum = int'(last_owner_q) + k;
      if (sum >= N_REQ) sum = sum - N_REQ;
      cand = ID_W'(sum);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  assign bit_s    = x_in[owner_q];
  assign hit_next = hit_q | (prev_q & bit_s);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    prev_d       = prev_q;
    hit_d        = hit_q;
    done_id_d    = done_id_q;
    done_hit_d   = done_hit_q;
    done_abort_d = done_abort_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d = S_STREAM;
          owner_d = pick_id;
          cnt_d   = '0;
          prev_d  = 1'b0;
          hit_d   = 1'b0;
        end
      end
      S_STREAM: begin
        if (!req[owner_q]) begin
          state_d      = S_REPORT;
          done_id_d    = owner_q;
          done_hit_d   = 1'b0;
          done_abort_d = 1'b1;
        end else begin
          hit_d  = hit_next;
          prev_d = bit_s;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d      = S_REPORT;
            done_id_d    = owner_q;
            done_hit_d   = hit_next;
            done_abort_d = 1'b0;
          end
        end
      end
      S_REPORT: begin
        last_owner_d = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_owner_q <= ID_LAST;
      cnt_q        <= '0;
      prev_q       <= 1'b0;
      hit_q        <= 1'b0;
      done_id_q    <= '0;
      done_hit_q   <= 1'b0;
      done_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      hit_q        <= hit_d;
      done_id_q    <= done_id_d;
      done_hit_q   <= done_hit_d;
      done_abort_q <= done_abort_d;
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q == S_STREAM) gnt[owner_q] = 1'b1;
  end

  assign busy       = (state_q == S_STREAM) || (state_q == S_REPORT);
  assign done       = (state_q == S_REPORT);
  assign done_id    = done_id_q;
  assign done_hit   = done_hit_q;
  assign done_abort = done_abort_q;

endmodule
